// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder arbiter.
package serial_add_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/serial_add_arbiter_if.sv
// Request/result bundle between two requesters, a result consumer and the shared adder.
interface serial_add_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_id;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_sum, res_cout, res_id
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_sum, res_cout, res_id
    );

endinterface

// File: rtl/fa_from_ha.sv
// One-bit full adder assembled from two half adders; the only arithmetic in the shared datapath.
module ha2 (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module fa_from_ha (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic s1;
    logic c1;
    logic c2;

    ha2 u_ha_ab  (.a(a),  .b(b),   .s(s1),  .c(c1));
    ha2 u_ha_cin (.a(s1), .b(cin), .s(sum), .c(c2));

    assign cout = c1 | c2;
endmodule

// File: rtl/serial_add_arbiter.sv
// Round-robin arbiter feeding two requesters into one LSB-first bit-serial adder.
//   state  | meaning
//   IDLE   | waiting for a request; grant issued combinationally
//   RUN    | adding one bit per cycle, WIDTH cycles
//   DONE   | result presented until the consumer takes it
module serial_add_arbiter
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_add_arbiter_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_sum_q, res_sum_d;
    logic             res_cout_q, res_cout_d;
    logic             res_id_q, res_id_d;

    logic grant;
    logic accept;
    logic fa_s;
    logic fa_c;

    // With both requesters valid the one not served last wins.
    assign grant = (bus.req0_valid && !(bus.req1_valid && last_grant_q == ID_REQ0))
                   ? ID_REQ0 : ID_REQ1;

    assign bus.req0_ready = (state_q == S_IDLE) && !reset && bus.req0_valid && (grant == ID_REQ0);
    assign bus.req1_ready = (state_q == S_IDLE) && !reset && bus.req1_valid && (grant == ID_REQ1);
    assign accept         = bus.req0_ready || bus.req1_ready;

    fa_from_ha u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_s),
        .cout (fa_c)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        sum_sh_d     = sum_sh_q;
        carry_d      = carry_q;
        cnt_d        = cnt_q;
        res_sum_d    = res_sum_q;
        res_cout_d   = res_cout_q;
        res_id_d     = res_id_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d      = S_RUN;
                    a_sh_d       = (grant == ID_REQ1) ? bus.req1_a : bus.req0_a;
                    b_sh_d       = (grant == ID_REQ1) ? bus.req1_b : bus.req0_b;
                    sum_sh_d     = '0;
                    carry_d      = 1'b0;
                    cnt_d        = '0;
                    res_id_d     = grant;
                    last_grant_d = grant;
                end
            end
            S_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                carry_d  = fa_c;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d    = S_DONE;
                    res_sum_d  = sum_sh_d;
                    res_cout_d = fa_c;
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= ID_REQ1;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            sum_sh_q     <= '0;
            carry_q      <= 1'b0;
            cnt_q        <= '0;
            res_sum_q    <= '0;
            res_cout_q   <= 1'b0;
            res_id_q     <= ID_REQ0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            sum_sh_q     <= sum_sh_d;
            carry_q      <= carry_d;
            cnt_q        <= cnt_d;
            res_sum_q    <= res_sum_d;
            res_cout_q   <= res_cout_d;
            res_id_q     <= res_id_d;
        end
    end

    assign bus.res_valid = (state_q == S_DONE);
    assign bus.res_sum   = res_sum_q;
    assign bus.res_cout  = res_cout_q;
    assign bus.res_id    = res_id_q;

endmodule
